// File: rtl/activation_scheduler_if.sv
// Control, sample and result signals between the activation scheduler
// (slave) and its host/upstream/downstream environment (master).
interface activation_scheduler_if #(
   parameter int DATA_WIDTH = 16,
   parameter int TS_WIDTH   = 8
);
   logic                         start;
   logic [TS_WIDTH-1:0]          num_timesteps;
   logic                         cfg_we;
   logic signed [DATA_WIDTH-1:0] cfg_threshold;
   logic signed [DATA_WIDTH-1:0] threshold;
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_potential;
   logic signed [DATA_WIDTH-1:0] membrane_potential;
   logic                         step_en;
   logic                         reset_accumulated_spikes;
   logic signed [DATA_WIDTH-1:0] acc_spikes;
   logic                         out_valid;
   logic                         out_ready;
   logic signed [DATA_WIDTH-1:0] out_spikes;
   logic                         busy;
   logic [TS_WIDTH-1:0]          timestep;
   logic                         done;

   modport slave (
      input  start, num_timesteps, cfg_we, cfg_threshold,
      input  in_valid, in_potential, acc_spikes, out_ready,
      output threshold, in_ready, membrane_potential, step_en,
      output reset_accumulated_spikes, out_valid, out_spikes,
      output busy, timestep, done
   );

   modport master (
      output start, num_timesteps, cfg_we, cfg_threshold,
      output in_valid, in_potential, acc_spikes, out_ready,
      input  threshold, in_ready, membrane_potential, step_en,
      input  reset_accumulated_spikes, out_valid, out_spikes,
      input  busy, timestep, done
   );
endinterface

// File: rtl/activation_scheduler.sv
// Sequences one spiking activation element through a T-timestep inference:
// clear accumulator, admit T samples, drain the element pipeline, hand off the count.
module activation_scheduler #(
   parameter int                           DATA_WIDTH   = 16,
   parameter int                           TS_WIDTH     = 8,
   parameter int                           PIPE_LAT     = 2,
   parameter logic signed [DATA_WIDTH-1:0] THRESH_RESET = 16'sd256
) (
   input  logic                  clk,
   input  logic                  rst,
   activation_scheduler_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_RUN,
      S_DRAIN,
      S_OUTPUT
   } state_t;

   localparam int                CNT_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
   localparam logic [CNT_W-1:0]  DRAIN_LOAD = CNT_W'(PIPE_LAT - 1);

   state_t                       r_state;
   logic [TS_WIDTH-1:0]          r_num_ts;
   logic [TS_WIDTH-1:0]          r_timestep;
   logic [CNT_W-1:0]             r_drain_cnt;
   logic signed [DATA_WIDTH-1:0] r_threshold;
   logic signed [DATA_WIDTH-1:0] r_out_spikes;
   logic                         r_busy;
   logic                         r_in_ready;
   logic                         r_clear_acc;
   logic                         r_out_valid;

   logic                         w_start_ok;
   logic                         w_handshake;
   logic                         w_last_step;

   // A zero-length inference request is dropped rather than run.
   assign w_start_ok  = bus.start && (bus.num_timesteps != '0);
   assign w_handshake = r_in_ready && bus.in_valid;
   assign w_last_step = (r_timestep == (r_num_ts - TS_WIDTH'(1)));

   // NOTE: every register here is assigned with <= so all of them see the
   // pre-edge values of each other regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_num_ts     <= '0;
         r_timestep   <= '0;
         r_drain_cnt  <= '0;
         r_threshold  <= THRESH_RESET;
         r_out_spikes <= '0;
         r_busy       <= 1'b0;
         r_in_ready   <= 1'b0;
         r_clear_acc  <= 1'b0;
         r_out_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cfg_we) begin
                  r_threshold <= bus.cfg_threshold;
               end
               if (w_start_ok) begin
                  r_num_ts    <= bus.num_timesteps;
                  r_timestep  <= '0;
                  r_busy      <= 1'b1;
                  r_clear_acc <= 1'b1;
                  r_state     <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               r_clear_acc <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_RUN;
            end

            S_RUN: begin
               if (w_handshake) begin
                  r_timestep <= r_timestep + TS_WIDTH'(1);
                  if (w_last_step) begin
                     r_drain_cnt <= DRAIN_LOAD;
                     r_in_ready  <= 1'b0;
                     r_state     <= S_DRAIN;
                  end
               end
            end

            // Wait out the element latency so acc_spikes includes the last step.
            S_DRAIN: begin
               if (r_drain_cnt == '0) begin
                  r_out_spikes <= bus.acc_spikes;
                  r_out_valid  <= 1'b1;
                  r_state      <= S_OUTPUT;
               end else begin
                  r_drain_cnt <= r_drain_cnt - CNT_W'(1);
               end
            end

            S_OUTPUT: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            default: begin
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b0;
               r_clear_acc <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.threshold                = r_threshold;
   assign bus.in_ready                 = r_in_ready;
   assign bus.step_en                  = w_handshake;
   assign bus.membrane_potential       = w_handshake ? bus.in_potential : '0;
   assign bus.reset_accumulated_spikes = r_clear_acc;
   assign bus.out_valid                = r_out_valid;
   assign bus.out_spikes               = r_out_spikes;
   assign bus.busy                     = r_busy;
   assign bus.timestep                 = r_timestep;
   assign bus.done                     = r_out_valid && bus.out_ready;

   a_step_only_when_ready : assert property (
      @(posedge clk) disable iff (rst) bus.step_en |-> bus.in_ready);

   a_valid_drops_after_done : assert property (
      @(posedge clk) disable iff (rst) bus.done |=> !bus.out_valid);

   a_result_held_under_backpressure : assert property (
      @(posedge clk) disable iff (rst)
      (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_spikes)));

endmodule

// File: doc/activation_scheduler.md
# activation_scheduler

Sequences one spiking activation element through a multi-timestep inference: it clears the spike accumulator, admits one membrane-potential sample per timestep from upstream, waits for the threshold/accumulator pipeline to drain, and presents the final accumulated spike count downstream. It also owns the threshold configuration register. It sits between the membrane-potential producer and the activation element, and gates that element's timing.

## Interface
- DATA_WIDTH, 16, width of membrane potential, threshold and spike count
- TS_WIDTH, 8, width of timestep count and counter
- PIPE_LAT, 2, cycles from a step_en pulse until acc_spikes reflects that step; must be ≥1
- THRESH_RESET, 16'sd256, threshold value after reset

Ports:
- clk  in  1  clock; all state changes on its rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request to begin an inference; sampled only in IDLE
- num_timesteps  in  TS_WIDTH  timesteps T per inference; latched on accepted start
- cfg_we  in  1  threshold write strobe; honoured only in IDLE
- cfg_threshold  in  DATA_WIDTH signed  threshold write data
- threshold  out  DATA_WIDTH signed  registered threshold to the element
- in_valid  in  1  upstream membrane-potential sample valid
- in_ready  out  1  scheduler accepts a sample
- in_potential  in  DATA_WIDTH signed  upstream sample
- membrane_potential  out  DATA_WIDTH signed  sample forwarded to the element
- step_en  out  1  element evaluates membrane_potential this cycle
- reset_accumulated_spikes  out  1  clear the element's accumulator
- acc_spikes  in  DATA_WIDTH signed  accumulated spike count from the element
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_spikes  out  DATA_WIDTH signed  captured final count
- busy  out  1  high in any state other than IDLE
- timestep  out  TS_WIDTH  number of samples accepted in the current inference
- done  out  1  one-cycle pulse on result handoff

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, OUTPUT.
- IDLE: in_ready=0, busy=0. If start=1 and num_timesteps≠0, latch T, clear timestep, and go to CLEAR. If start=1 and num_timesteps=0, ignore the request and stay in IDLE. cfg_we=1 loads threshold on the next edge. If cfg_we and start occur in the same cycle, the write is applied and the run uses the new threshold.
- CLEAR: one cycle with reset_accumulated_spikes=1, then RUN.
- RUN: in_ready=1. A handshake occurs when in_valid & in_ready. On a handshake:
  - step_en=1 combinationally in the same cycle.
  - membrane_potential=in_potential combinationally.
  - timestep increments.
  - On the handshake where timestep==T-1, go to DRAIN and load the drain counter with PIPE_LAT-1.
- RUN with no handshake: the scheduler stalls indefinitely, and step_en stays 0.
- Outside a handshake, membrane_potential is 0.
- DRAIN: in_ready=0. Count down. In the cycle the counter is 0, register out_spikes←acc_spikes and go to OUTPUT.
- OUTPUT: out_valid=1 and out_spikes is held stable. On out_ready=1, pulse done=1 in that cycle and go to IDLE. out_valid drops on the next edge.
- start, cfg_we and in_valid are ignored outside their states. Changes to num_timesteps after latch have no effect.
- timestep holds its final value (T) through DRAIN and OUTPUT, and is cleared on the next accepted start.

## Timing
- Reset values: state=IDLE, threshold=THRESH_RESET, out_spikes=0, timestep=0, drain counter=0. All single-bit outputs are 0.
- Reset mid-operation immediately returns to IDLE. It discards any latched T and pending result, and produces no done pulse.
- Start accepted at edge 0 → CLEAR during cycle 1 → RUN from cycle 2. The earliest first handshake is in cycle 2.
- With in_valid held high, the T handshakes occur in cycles 2..T+1. DRAIN spans cycles T+2..T+1+PIPE_LAT. out_valid first rises in cycle T+2+PIPE_LAT.
- Minimum inference time, start to done with out_ready=1, is T+3+PIPE_LAT cycles.
- Back-to-back: start can be accepted in the first IDLE cycle after done.
- Throughput: at most one sample per cycle. No sample is accepted in CLEAR, DRAIN or OUTPUT.

## Test plan
- Reset then idle: assert rst mid-clock → all outputs 0, threshold=256 with no clock edge. Release, hold 5 cycles → busy=0, in_ready=0.
- Basic run, T=4, PIPE_LAT=2, in_valid always 1, out_ready=1:
  - Start at cycle 0 → reset_accumulated_spikes in cycle 1, step_en in cycles 2–5.
  - out_valid in cycle 8 with out_spikes = acc_spikes sampled in cycle 7; done pulses in cycle 8.
- Stalls: T=3 with in_valid toggling 1,0,0,1,0,1 → exactly 3 step_en pulses aligned with in_valid=1, timestep=3, then DRAIN.
- Backpressure and config lock: out_ready=0 for 10 cycles in OUTPUT → out_valid and out_spikes stable and no done. cfg_we with 100 during RUN → threshold unchanged. cfg_we with 100 in IDLE → threshold=100.
- Edge cases:
  - start with num_timesteps=0 → remains IDLE, no reset_accumulated_spikes.
  - start during RUN → ignored, timestep unaffected.
  - T=255 → completes with timestep=255.
- Reset mid-run: rst during timestep 2 of T=4 → IDLE immediately, no done. A new start afterwards runs a full T=4 from timestep=0.
